edge_enhance: RTL

- Spatial sharpening stage directly downstream of the 2D/3D noise-reduction stage in the ISP RGB pipe.
- Consumes the denoised 24-bit RGB pixel stream (R[23:16], G[15:8], B[7:0]) and applies a per-channel 3x3 Laplacian unsharp mask with programmable gain.
- Buffers two lines internally and emits a sharpened raster-order stream with frame-start marking and sticky error flags.

---
 rtl/edge_enhance.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/edge_enhance.sv
`default_nettype none
// ============================================================================
//  Module      : edge_enhance
//  Description : Per-channel 3x3 Laplacian unsharp mask for a 24-bit RGB
//                raster stream. Two internal line buffers, a 3x3 window
//                register and an arithmetic/output register stage. Emits a
//                sharpened raster stream with frame-start marking and sticky
//                error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_enhance #(
    parameter int MAX_WIDTH = 4096,
    parameter int GAIN_FRAC = 6
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cfg_enable_i,
    input  logic [7:0]  cfg_gain_i,
    input  logic [12:0] cfg_width_i,
    input  logic [12:0] cfg_height_i,
    input  logic [23:0] rgb_data_i,
    input  logic        rgb_valid_i,
    input  logic        rgb_sof_i,
    output logic [23:0] rgb_sharp_o,
    output logic        rgb_valid_o,
    output logic        rgb_sof_o,
    output logic        busy_o,
    output logic [2:0]  err_o,
    input  logic        err_clr_i
);
    localparam int AW = (MAX_WIDTH > 2) ? $clog2(MAX_WIDTH) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_TAIL  = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [12:0] row_q, row_d, col_q, col_d;
    logic [12:0] width_q, height_q;
    logic        enable_q;
    logic [7:0]  gain_q;
    logic [2:0]  err_q, err_set;

    logic        sof_in, cfg_ok, last_col, last_row;
    logic        cfg_ld, lb_we, shift, flush_ld, emit, emit_sof, emit_border;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [23:0] lb_a_rd, lb_b_rd;

    // lb_a holds the previous input row, lb_b the row before that
    logic [23:0] lb_a_q [MAX_WIDTH];
    logic [23:0] lb_b_q [MAX_WIDTH];

    // window: [row][col], row 0 = oldest line, col 2 = newest column
    logic [23:0] win_q [3][3];
    logic        s1_valid_q, s1_sof_q, s1_pass_q;
    logic [23:0] sharp_q, sharp_calc;
    logic        valid_q, osof_q;

    assign sof_in   = rgb_valid_i & rgb_sof_i;
    assign cfg_ok   = (cfg_width_i >= 13'd3) && (cfg_width_i <= 13'(MAX_WIDTH)) &&
                      (cfg_height_i >= 13'd3);
    assign last_col = (col_q == width_q - 13'd1);
    assign last_row = (row_q == height_q - 13'd1);
    assign rd_addr  = col_q[AW-1:0];
    assign wr_addr  = sof_in ? '0 : col_q[AW-1:0];
    assign lb_a_rd  = lb_a_q[rd_addr];
    assign lb_b_rd  = lb_b_q[rd_addr];

    // Frame sequencing: decides what each cycle stores, shifts and emits
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        cfg_ld      = 1'b0;
        lb_we       = 1'b0;
        shift       = 1'b0;
        flush_ld    = 1'b0;
        emit        = 1'b0;
        emit_sof    = 1'b0;
        emit_border = 1'b0;
        err_set     = 3'b000;
        if (sof_in) begin
            // A SOF always restarts; any frame still in flight is abandoned
            cfg_ld = 1'b1;
            if (state_q != ST_IDLE) err_set[2] = 1'b1;
            row_d = 13'd0;
            if (cfg_ok) begin
                state_d = ST_FILL;
                lb_we   = 1'b1;
                col_d   = 13'd1;
            end else begin
                err_set[1] = 1'b1;
                state_d    = ST_IDLE;
                col_d      = 13'd0;
            end
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (rgb_valid_i) begin
                        lb_we = 1'b1;
                        if (last_col) begin
                            state_d = ST_RUN;
                            row_d   = 13'd1;
                            col_d   = 13'd0;
                        end else begin
                            col_d = col_q + 13'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (rgb_valid_i) begin
                        lb_we       = 1'b1;
                        shift       = 1'b1;
                        emit        = (col_q != 13'd0);
                        emit_sof    = (row_q == 13'd1) && (col_q == 13'd1);
                        emit_border = (row_q == 13'd1) || (col_q == 13'd1);
                        if (last_col) begin
                            state_d = ST_TAIL;
                            col_d   = 13'd0;
                        end else begin
                            col_d = col_q + 13'd1;
                        end
                    end
                end
                ST_TAIL: begin
                    shift       = 1'b1;
                    emit        = 1'b1;
                    emit_border = 1'b1;
                    err_set[0]  = rgb_valid_i;
                    if (last_row) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_RUN;
                        row_d   = row_q + 13'd1;
                    end
                end
                ST_FLUSH: begin
                    flush_ld    = 1'b1;
                    emit        = 1'b1;
                    emit_border = 1'b1;
                    err_set[0]  = rgb_valid_i;
                    if (last_col) begin
                        state_d = ST_IDLE;
                        row_d   = 13'd0;
                        col_d   = 13'd0;
                    end else begin
                        col_d = col_q + 13'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state, latched frame configuration and sticky errors
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            row_q    <= 13'd0;
            col_q    <= 13'd0;
            width_q  <= 13'd0;
            height_q <= 13'd0;
            enable_q <= 1'b0;
            gain_q   <= 8'd0;
            err_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            if (cfg_ld) begin
                width_q  <= cfg_width_i;
                height_q <= cfg_height_i;
                enable_q <= cfg_enable_i;
                gain_q   <= cfg_gain_i;
            end
            err_q <= (err_q & {3{~err_clr_i}}) | err_set;
        end
    end

    // Line buffers: read-before-write moves each column up one line
    always_ff @(posedge clk_i) begin
        if (lb_we) begin
            lb_b_q[wr_addr] <= lb_a_q[wr_addr];
            lb_a_q[wr_addr] <= rgb_data_i;
        end
    end

    // Window register: shift in a new column, or load the center during flush
    always_ff @(posedge clk_i) begin
        if (shift) begin
            for (int k = 0; k < 3; k++) begin
                win_q[k][0] <= win_q[k][1];
                win_q[k][1] <= win_q[k][2];
            end
            win_q[0][2] <= lb_b_rd;
            win_q[1][2] <= lb_a_rd;
            win_q[2][2] <= rgb_data_i;
        end else if (flush_ld) begin
            win_q[1][1] <= lb_a_rd;
        end
    end

    // Window-stage qualifiers travel alongside the window contents
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_pass_q  <= 1'b0;
        end else begin
            s1_valid_q <= emit;
            s1_sof_q   <= emit_sof;
            s1_pass_q  <= emit_border | ~enable_q;
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic [7:0]         ctr;
        logic [10:0]        nsum;
        logic signed [12:0] lap;
        logic signed [20:0] lap_x, gain_x, prod, delta, ctr_x, sum;

        assign ctr   = win_q[1][1][ch*8 +: 8];
        assign nsum  = 11'(win_q[0][0][ch*8 +: 8]) + 11'(win_q[0][1][ch*8 +: 8]) +
                       11'(win_q[0][2][ch*8 +: 8]) + 11'(win_q[1][0][ch*8 +: 8]) +
                       11'(win_q[1][2][ch*8 +: 8]) + 11'(win_q[2][0][ch*8 +: 8]) +
                       11'(win_q[2][1][ch*8 +: 8]) + 11'(win_q[2][2][ch*8 +: 8]);
        assign lap   = $signed({2'b00, ctr, 3'b000}) - $signed({2'b00, nsum});
        assign lap_x = 21'(lap);
        assign gain_x = $signed(21'({1'b0, gain_q}));
        assign prod  = lap_x * gain_x;
        assign delta = prod >>> GAIN_FRAC;
        assign ctr_x = $signed({13'd0, ctr});
        assign sum   = ctr_x + delta;
        assign sharp_calc[ch*8 +: 8] = sum[20]        ? 8'd0   :
                                       (|sum[19:8])   ? 8'hff  : sum[7:0];
    end

    // Output register: border and bypass pixels pass the center unchanged
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sharp_q <= 24'd0;
            valid_q <= 1'b0;
            osof_q  <= 1'b0;
        end else begin
            valid_q <= s1_valid_q;
            osof_q  <= s1_sof_q;
            if (s1_valid_q) sharp_q <= s1_pass_q ? win_q[1][1] : sharp_calc;
        end
    end

    assign rgb_sharp_o = sharp_q;
    assign rgb_valid_o = valid_q;
    assign rgb_sof_o   = osof_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err_q;

endmodule
`default_nettype wire
